// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_ADDR_W = 64;

endpackage

// File: rtl/arb_timeout_counter.sv
// Wait-state counter for one memory transfer; expired flags the last allowed XFER cycle.
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // count holds the number of XFER cycles already completed, so the
    // TIMEOUT-th cycle is the one where count equals TIMEOUT-1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the CPU and a DMA reader,
// with registered strobes, per-requester ack pulses and a wait-state timeout.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    state_t state;
    owner_t owner;
    owner_t last_owner;
    owner_t winner;
    logic   we_r;
    logic   expired;
    logic   finish;

    // on a tie the requester that did not own the bus last time wins
    always_comb begin
        winner = OWN_DMA;
        if (cpu_req && (!dma_req || last_owner == OWN_DMA)) begin
            winner = OWN_CPU;
        end
    end

    assign finish = mem_ready || expired;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == IDLE),
        .enable  (state == XFER),
        .expired (expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DMA;
            we_r       <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    bus_err <= 1'b0;
                    if (cpu_req || dma_req) begin
                        owner      <= winner;
                        last_owner <= winner;
                        state      <= XFER;
                        if (winner == OWN_CPU) begin
                            we_r      <= cpu_we;
                            mem_read  <= ~cpu_we;
                            mem_write <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else begin
                            we_r      <= dma_we;
                            mem_read  <= ~dma_we;
                            mem_write <= dma_we;
                            mem_addr  <= dma_addr;
                            mem_wdata <= dma_wdata;
                        end
                    end
                end
                // completion takes priority over a timeout hitting on the same cycle
                XFER: begin
                    if (finish) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        bus_err   <= ~mem_ready;
                        state     <= DONE;
                        if (owner == OWN_CPU) begin
                            cpu_ack <= 1'b1;
                            if (!mem_ready) begin
                                cpu_rdata <= '0;
                            end else if (!we_r) begin
                                cpu_rdata <= mem_rdata;
                            end
                        end else begin
                            dma_ack <= 1'b1;
                            if (!mem_ready) begin
                                dma_rdata <= '0;
                            end else if (!we_r) begin
                                dma_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    bus_err <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter, built with TIMEOUT=4.
module tb_mem_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [63:0] cpu_rdata;
    logic        cpu_ack;
    logic        dma_req;
    logic        dma_we;
    logic [63:0] dma_addr;
    logic [63:0] dma_wdata;
    logic [63:0] dma_rdata;
    logic        dma_ack;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .DATA_W  (64),
        .ADDR_W  (64),
        .TIMEOUT (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic c_req, input logic c_we, input logic [63:0] c_addr,
                                 input logic d_req, input logic d_we, input logic [63:0] d_addr,
                                 input logic [63:0] d_wdata);
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        dma_req   = d_req;
        dma_we    = d_we;
        dma_addr  = d_addr;
        dma_wdata = d_wdata;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_mem_read"}, {63'd0, mem_read}, 64'd0);
        checkOutput({tag, "_mem_write"}, {63'd0, mem_write}, 64'd0);
        checkOutput({tag, "_cpu_ack"}, {63'd0, cpu_ack}, 64'd0);
        checkOutput({tag, "_dma_ack"}, {63'd0, dma_ack}, 64'd0);
        checkOutput({tag, "_bus_err"}, {63'd0, bus_err}, 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = 64'h0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // reset state
        #2;
        checkIdleOutputs("reset");
        checkOutput("reset_mem_addr", mem_addr, 64'd0);
        checkOutput("reset_cpu_rdata", cpu_rdata, 64'd0);
        #10;
        reset = 1'b1;

        // single CPU read with zero-wait memory
        $display("[TB] cpu read alone");
        mem_ready = 1'b1;
        mem_rdata = 64'hDEAD_BEEF;
        applyStimulus(1'b1, 1'b0, 64'h40, 1'b0, 1'b0, 64'h0, 64'h0);
        step();
        checkOutput("t1_mem_read", {63'd0, mem_read}, 64'd1);
        checkOutput("t1_mem_addr", mem_addr, 64'h40);
        checkOutput("t1_cpu_ack_early", {63'd0, cpu_ack}, 64'd0);
        step();
        checkOutput("t1_cpu_ack", {63'd0, cpu_ack}, 64'd1);
        checkOutput("t1_cpu_rdata", cpu_rdata, 64'hDEAD_BEEF);
        checkOutput("t1_dma_ack", {63'd0, dma_ack}, 64'd0);
        checkOutput("t1_mem_read_off", {63'd0, mem_read}, 64'd0);
        cpu_req = 1'b0;
        step();
        checkIdleOutputs("t1_idle");
        checkOutput("t1_rdata_hold", cpu_rdata, 64'hDEAD_BEEF);

        // tie from reset alternates CPU, DMA, CPU, DMA
        $display("[TB] round robin");
        reset = 1'b0;
        #3;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 64'h1000, 1'b1, 1'b0, 64'h2000, 64'h0);
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 64'hA0 + 64'(i);
            step();
            checkOutput($sformatf("rr%0d_mem_addr", i), mem_addr, (i % 2 == 0) ? 64'h1000 : 64'h2000);
            step();
            checkOutput($sformatf("rr%0d_cpu_ack", i), {63'd0, cpu_ack}, (i % 2 == 0) ? 64'd1 : 64'd0);
            checkOutput($sformatf("rr%0d_dma_ack", i), {63'd0, dma_ack}, (i % 2 == 0) ? 64'd0 : 64'd1);
            checkOutput($sformatf("rr%0d_rdata", i), (i % 2 == 0) ? cpu_rdata : dma_rdata, 64'hA0 + 64'(i));
            step();
        end
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        step();

        // DMA write with three wait states, ready on the timeout cycle
        $display("[TB] dma write with wait states");
        mem_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'h100, 64'h55);
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput($sformatf("wr_c%0d_mem_write", c), {63'd0, mem_write}, 64'd1);
            checkOutput($sformatf("wr_c%0d_mem_read", c), {63'd0, mem_read}, 64'd0);
            checkOutput($sformatf("wr_c%0d_mem_addr", c), mem_addr, 64'h100);
            checkOutput($sformatf("wr_c%0d_mem_wdata", c), mem_wdata, 64'h55);
            checkOutput($sformatf("wr_c%0d_dma_ack", c), {63'd0, dma_ack}, 64'd0);
        end
        mem_ready = 1'b1;
        step();
        checkOutput("wr_dma_ack", {63'd0, dma_ack}, 64'd1);
        checkOutput("wr_bus_err", {63'd0, bus_err}, 64'd0);
        checkOutput("wr_mem_write_off", {63'd0, mem_write}, 64'd0);
        checkOutput("wr_dma_rdata", dma_rdata, 64'hA3);
        dma_req = 1'b0;
        mem_ready = 1'b0;
        step();
        checkIdleOutputs("wr_idle");

        // CPU read that never sees mem_ready times out after four cycles
        $display("[TB] timeout");
        applyStimulus(1'b1, 1'b0, 64'h300, 1'b0, 1'b0, 64'h0, 64'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput($sformatf("to_c%0d_mem_read", c), {63'd0, mem_read}, 64'd1);
            checkOutput($sformatf("to_c%0d_cpu_ack", c), {63'd0, cpu_ack}, 64'd0);
        end
        step();
        checkOutput("to_cpu_ack", {63'd0, cpu_ack}, 64'd1);
        checkOutput("to_bus_err", {63'd0, bus_err}, 64'd1);
        checkOutput("to_cpu_rdata", cpu_rdata, 64'd0);
        cpu_req = 1'b0;
        step();
        checkIdleOutputs("to_idle");

        // next request after a timeout completes normally
        mem_ready = 1'b1;
        mem_rdata = 64'h77;
        cpu_req   = 1'b1;
        step();
        checkOutput("post_mem_read", {63'd0, mem_read}, 64'd1);
        step();
        checkOutput("post_cpu_ack", {63'd0, cpu_ack}, 64'd1);
        checkOutput("post_bus_err", {63'd0, bus_err}, 64'd0);
        checkOutput("post_cpu_rdata", cpu_rdata, 64'h77);
        cpu_req = 1'b0;
        step();

        // ready arriving on the 4th XFER cycle beats the timeout
        $display("[TB] ready on timeout cycle");
        mem_ready = 1'b0;
        mem_rdata = 64'hABC;
        cpu_req   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
        end
        mem_ready = 1'b1;
        step();
        checkOutput("tie_cpu_ack", {63'd0, cpu_ack}, 64'd1);
        checkOutput("tie_bus_err", {63'd0, bus_err}, 64'd0);
        checkOutput("tie_cpu_rdata", cpu_rdata, 64'hABC);
        cpu_req = 1'b0;
        step();

        // asynchronous reset mid-transfer
        $display("[TB] async reset mid xfer");
        mem_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 64'h500, 1'b0, 1'b0, 64'h0, 64'h0);
        step();
        checkOutput("ar_mem_read_before", {63'd0, mem_read}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        checkIdleOutputs("ar_async");
        checkOutput("ar_mem_addr", mem_addr, 64'd0);
        checkOutput("ar_cpu_rdata", cpu_rdata, 64'd0);
        #4;
        reset = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 64'h99;
        applyStimulus(1'b1, 1'b0, 64'h600, 1'b1, 1'b0, 64'h700, 64'h0);
        step();
        checkOutput("ar_tie_mem_addr", mem_addr, 64'h600);
        step();
        checkOutput("ar_tie_cpu_ack", {63'd0, cpu_ack}, 64'd1);
        checkOutput("ar_tie_dma_ack", {63'd0, dma_ack}, 64'd0);
        checkOutput("ar_tie_cpu_rdata", cpu_rdata, 64'h99);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the processor's single 64-bit data-memory port between two requesters: the CPU datapath (load/store) and a DMA/screen-refresh reader.
- Round-robin arbitration, one transfer per grant.
- Registered strobes to memory.
- Per-requester acknowledge, with a wait-state timeout that aborts a hung transfer.
- Sits between Processor and the data memory/peripheral bus.

Parameters:
DATA_W, 64, data width of all data buses
ADDR_W, 64, address width of all address buses
TIMEOUT, 255, maximum XFER cycles waiting for mem_ready before abort (1..2^16-1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
cpu_req  input  1  CPU transfer request; held until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_rdata  output  DATA_W  read data, valid while cpu_ack=1
cpu_ack  output  1  one-cycle completion pulse
dma_req  input  1  DMA request; held until dma_ack
dma_we  input  1  1 = write, 0 = read
dma_addr  input  ADDR_W  DMA address
dma_wdata  input  DATA_W  DMA write data
dma_rdata  output  DATA_W  read data, valid while dma_ack=1
dma_ack  output  1  one-cycle completion pulse
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, sampled when mem_ready=1
mem_ready  input  1  memory completes the current access this cycle
bus_err  output  1  pulses with the ack of a timed-out transfer

Behaviour:
- Reset (reset=0, async): state=IDLE, last_owner=DMA, all outputs 0, timeout counter 0. Assertion mid-transfer abandons it silently; no ack is issued.
- FSM states: IDLE, XFER, DONE.
- IDLE: sample cpu_req/dma_req.
  - One requester high: it wins.
  - Both high: the requester that is not last_owner wins.
  - On a grant, register owner, we, addr and wdata (captured at grant), set last_owner=winner, go to XFER.
  - No request: stay in IDLE.
- XFER:
  - mem_read=~we_r, mem_write=we_r, mem_addr/mem_wdata from the captured registers. Strobes hold steady until exit.
  - Counter increments every XFER cycle.
  - mem_ready=1: capture mem_rdata (reads only) into the owner's rdata register, go to DONE with err=0.
  - Counter reaches TIMEOUT with mem_ready=0: go to DONE with err=1 and rdata=0.
  - mem_ready=1 on the same cycle as the timeout hit: completion wins, err=0.
- DONE:
  - Strobes low; owner's ack=1 for exactly this cycle; bus_err=err.
  - Owner's rdata holds its value until the next completion for that owner (0 after a timeout).
  - Next state is IDLE.
- Latency with zero-wait memory: request sampled at edge N, strobe high in cycle N+1, ack in cycle N+2. Minimum 3 cycles per transfer.
- A requester must drop or change req on the edge after ack. req still high in IDLE is treated as a new request.
- req dropped during XFER: the transfer still completes and ack still pulses.
- The non-owner's ack is always 0; both acks are never high together.
- Write transfers leave rdata unchanged.
- mem_ready outside XFER is ignored.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE=2'd0, XFER=2'd1, DONE=2'd2)
  - owner encoding (OWN_CPU=1'b0, OWN_DMA=1'b1)
  - default DATA_W/ADDR_W constants
- One sub-module: arb_timeout_counter.
  - Ports: clock, reset, clear, enable, expired.
  - Width derived from TIMEOUT.
  - Cleared on entry to XFER.
- Arbitration and datapath muxing stay in the top module.

Test Plan:
- CPU read alone, mem_ready tied 1, mem_rdata=64'hDEAD_BEEF -> mem_read high 1 cycle after req sampled; cpu_ack and cpu_rdata=64'hDEAD_BEEF 2 cycles after; dma_ack stays 0.
- cpu_req and dma_req high together from reset, both held and re-requested -> grant order CPU, DMA, CPU, DMA; mem_addr alternates cpu_addr/dma_addr.
- DMA write addr=64'h100, wdata=64'h55, mem_ready low 3 XFER cycles then 1 -> mem_write held 4 cycles with stable addr/data; dma_ack one pulse; dma_rdata unchanged.
- TIMEOUT=4, mem_ready never asserted -> exactly 4 XFER cycles, then cpu_ack=1, bus_err=1, cpu_rdata=0; next request proceeds normally.
- TIMEOUT=4, mem_ready=1 on the 4th XFER cycle -> normal completion, bus_err=0.
- reset driven 0 asynchronously mid-XFER -> all outputs 0 immediately with no clock edge; after release, a tie resolves to CPU first.
